// File: rtl/fft_pkg.sv
// Shared encodings and helpers for the FFT frame sequencer.
package fft_pkg;

    localparam logic [1:0] CMD_LOAD    = 2'b00;
    localparam logic [1:0] CMD_XFORM   = 2'b01;
    localparam logic [1:0] CMD_READ    = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_XFORM = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int MAX_LOG2N = 10;

    function automatic int log2n(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Reverses the low 'bits' bits of k; higher bits come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] k, input int bits);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < bits) r[i] = k[bits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT address generator: maps (stage, pair) to top/bottom operand
// addresses and the twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    i_stage,
    input  logic [LOG2N-2:0] i_pair,
    output logic [LOG2N-1:0] o_top,
    output logic [LOG2N-1:0] o_bot,
    output logic [LOG2N-2:0] o_twi
);

    localparam int PW = LOG2N - 1;

    logic [PW-1:0]    w_one_p;
    logic [PW-1:0]    w_mask;
    logic [PW-1:0]    w_low;
    logic [PW-1:0]    w_high;
    logic [LOG2N-1:0] w_one;

    assign w_one_p = PW'(1);
    assign w_one   = LOG2N'(1);

    // In the last stage 1<<s overflows to zero, so the mask becomes all ones.
    assign w_mask = (w_one_p << i_stage) - w_one_p;
    assign w_low  = i_pair & w_mask;
    assign w_high = i_pair & ~w_mask;

    assign o_top = {w_high, 1'b0} | {1'b0, w_low};
    assign o_bot = o_top | (w_one << i_stage);
    assign o_twi = w_low << (PW - int'(i_stage));

endmodule

// File: rtl/fft_sequencer.sv
// Command-driven FFT frame sequencer: LOAD (bit-reversed writes), TRANSFORM
// (ping-pong radix-2 stages with drain gaps) and READ (ready-gated issue).
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N        = 16,
    parameter int RD_LAT   = 1,
    parameter int BFLY_LAT = 2,
    parameter int LOG2N    = log2n(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    input  logic [1:0]               i_cmd,
    input  logic                     i_inverse,
    output logic                     o_cmd_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic                     o_out_valid,
    output logic                     o_out_last,
    input  logic                     i_out_ready,
    output logic                     o_rd_en,
    output logic                     o_rd_bank,
    output logic [LOG2N-1:0]         o_rd_addr,
    output logic                     o_wr_en,
    output logic                     o_wr_bank,
    output logic [LOG2N-1:0]         o_wr_addr,
    output logic                     o_wr_src,
    output logic                     o_phase,
    output logic                     o_twi_en,
    output logic [LOG2N-2:0]         o_twi_addr,
    output logic                     o_twi_conj,
    output logic [$clog2(LOG2N)-1:0] o_stage,
    output logic [2:0]               o_dbg_state
);

    localparam int   PW       = LOG2N - 1;
    localparam int   SW       = $clog2(LOG2N);
    localparam int   D        = RD_LAT + BFLY_LAT;
    localparam int   DW       = $clog2(D + 1) + 1;
    localparam logic RES_BANK = (LOG2N % 2) == 1;

    logic [2:0]       r_state;
    logic [LOG2N-1:0] r_k;
    logic [PW-1:0]    r_pair;
    logic             r_phase;
    logic [SW-1:0]    r_stage;
    logic [DW-1:0]    r_drain;
    logic             r_conj;
    logic             r_iss_done;
    logic             r_err;

    logic             r_wp_vld   [D];
    logic [LOG2N-1:0] r_wp_addr  [D];
    logic             r_wp_phase [D];
    logic             r_wp_bank  [D];
    logic             r_ov       [RD_LAT];
    logic             r_ol       [RD_LAT];

    logic             w_xf_rd;
    logic             w_issue;
    logic             w_load_wr;
    logic [LOG2N-1:0] w_top;
    logic [LOG2N-1:0] w_bot;
    logic [LOG2N-2:0] w_twi;
    logic [LOG2N-1:0] w_xf_addr;
    logic [LOG2N-1:0] w_brev;

    fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_addr_gen (
        .i_stage (r_stage),
        .i_pair  (r_pair),
        .o_top   (w_top),
        .o_bot   (w_bot),
        .o_twi   (w_twi)
    );

    // Handshakes: an input sample transfers when i_in_valid & o_in_ready; a
    // result read issues only when i_out_ready, and the sink must then take
    // o_out_valid exactly RD_LAT cycles later (no stall once in flight).
    assign w_xf_rd   = (r_state == ST_XFORM);
    assign w_issue   = (r_state == ST_READ) && i_out_ready && !r_iss_done;
    assign w_load_wr = (r_state == ST_LOAD) && i_in_valid;
    assign w_xf_addr = r_phase ? w_bot : w_top;
    assign w_brev    = LOG2N'(bitrev(MAX_LOG2N'(r_k), LOG2N));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_pair     <= '0;
            r_phase    <= 1'b0;
            r_stage    <= '0;
            r_drain    <= '0;
            r_conj     <= 1'b0;
            r_iss_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        case (i_cmd)
                            CMD_LOAD: begin
                                r_state <= ST_LOAD;
                                r_k     <= '0;
                            end
                            CMD_XFORM: begin
                                r_state <= ST_XFORM;
                                r_stage <= '0;
                                r_pair  <= '0;
                                r_phase <= 1'b0;
                                r_conj  <= i_inverse;
                            end
                            CMD_READ: begin
                                r_state    <= ST_READ;
                                r_k        <= '0;
                                r_iss_done <= 1'b0;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (i_in_valid) begin
                        if (r_k == LOG2N'(N - 1)) begin
                            r_k     <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_XFORM: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        if (r_pair == PW'(N / 2 - 1)) begin
                            r_pair  <= '0;
                            r_drain <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_pair <= r_pair + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // D+1 idle cycles let the last butterfly write land before the next stage reads it.
                    if (r_drain == DW'(D)) begin
                        r_drain <= '0;
                        if (r_stage == SW'(LOG2N - 1)) begin
                            r_stage <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_state <= ST_XFORM;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        if (r_k == LOG2N'(N - 1)) begin
                            r_k        <= '0;
                            r_iss_done <= 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                    if (o_out_valid && o_out_last) begin
                        r_iss_done <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < D; i++) begin
                r_wp_vld[i]   <= 1'b0;
                r_wp_addr[i]  <= '0;
                r_wp_phase[i] <= 1'b0;
                r_wp_bank[i]  <= 1'b0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                r_ov[i] <= 1'b0;
                r_ol[i] <= 1'b0;
            end
        end else begin
            r_wp_vld[0]   <= w_xf_rd;
            r_wp_addr[0]  <= w_xf_addr;
            r_wp_phase[0] <= r_phase;
            r_wp_bank[0]  <= ~r_stage[0];
            for (int i = 1; i < D; i++) begin
                r_wp_vld[i]   <= r_wp_vld[i-1];
                r_wp_addr[i]  <= r_wp_addr[i-1];
                r_wp_phase[i] <= r_wp_phase[i-1];
                r_wp_bank[i]  <= r_wp_bank[i-1];
            end
            r_ov[0] <= w_issue;
            r_ol[0] <= w_issue && (r_k == LOG2N'(N - 1));
            for (int i = 1; i < RD_LAT; i++) begin
                r_ov[i] <= r_ov[i-1];
                r_ol[i] <= r_ol[i-1];
            end
        end
    end

    always_comb begin
        o_rd_en   = 1'b0;
        o_rd_bank = 1'b0;
        o_rd_addr = '0;
        if (w_xf_rd) begin
            o_rd_en   = 1'b1;
            o_rd_bank = r_stage[0];
            o_rd_addr = w_xf_addr;
        end else if (w_issue) begin
            o_rd_en   = 1'b1;
            o_rd_bank = RES_BANK;
            o_rd_addr = r_k;
        end
    end

    always_comb begin
        o_wr_en   = 1'b0;
        o_wr_bank = 1'b0;
        o_wr_addr = '0;
        o_wr_src  = 1'b0;
        o_phase   = 1'b0;
        if (r_wp_vld[D-1]) begin
            o_wr_en   = 1'b1;
            o_wr_bank = r_wp_bank[D-1];
            o_wr_addr = r_wp_addr[D-1];
            o_wr_src  = 1'b1;
            o_phase   = r_wp_phase[D-1];
        end else if (w_load_wr) begin
            o_wr_en   = 1'b1;
            o_wr_addr = w_brev;
        end
    end

    assign o_twi_en    = w_xf_rd && !r_phase;
    assign o_twi_addr  = o_twi_en ? w_twi : '0;
    assign o_twi_conj  = r_conj;
    assign o_stage     = r_stage;
    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_err       = r_err;
    assign o_in_ready  = (r_state == ST_LOAD);
    assign o_out_valid = r_ov[RD_LAT-1];
    assign o_out_last  = r_ol[RD_LAT-1];
    assign o_dbg_state = r_state;

endmodule
